apb_uart_slave: RTL and testbench
=================================

// Module: apb_uart_slave
// PURPOSE
//  APB slave register interface for the UART receiver peripheral; sits downstream of the RX data buffer.
//  Exposes received data, status and error flags to the bus, and generates the one-cycle data_read strobe.
//  Holds the software-programmable bit period and data size that configure the receiver.
// PARAMETERS
//  BP_W      14  width of bit_period configuration register
//  BP_RST    10  reset value of bit_period (clock cycles per bit)
//  DS_RST    8   reset value of data_size
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  n_rst          in   1      asynchronous active-low reset
//  psel           in   1      APB select
//  penable        in   1      APB enable (access phase)
//  pwrite         in   1      1 = write, 0 = read
//  paddr          in   3      register address
//  pwdata         in   8      write data
//  prdata         out  8      read data, registered
//  pslverr        out  1      transfer error, registered
//  rx_data        in   8      buffered packet from RX data buffer
//  data_ready     in   1      buffer holds unread data
//  overrun_error  in   1      buffer overrun flag
//  framing_error  in   1      stop-bit framing error flag
//  data_read      out  1      one-cycle strobe: host consumed rx_data
//  bit_period     out  BP_W   configured clocks per bit
//  data_size      out  4      configured data bits (5, 7 or 8)
// BEHAVIOUR
//  Reset (async, n_rst=0): state=IDLE, prdata=0, pslverr=0, data_read=0, bit_period=BP_RST, data_size=DS_RST.
//  Register map (paddr):
//   0 RO status  {7'b0, data_ready}
//   1 RO errors  {6'b0, overrun_error, framing_error}
//   2 RW bit_period[7:0]
//   3 RW bit_period[BP_W-1:8] (upper unused bits read 0, ignored on write)
//   4 RW data_size {4'b0, data_size}
//   6 RO rx data, right-justified by data_size: 8 -> rx_data; 7 -> {1'b0,rx_data[7:1]}; 5 -> {3'b0,rx_data[7:3]}
//   5,7 unmapped
//  FSM states: IDLE, READ, WRITE, ERROR. Zero wait states; every transfer is setup cycle then access cycle.
//   IDLE: on setup cycle (psel=1, penable=0), decode paddr/pwrite at the clock edge:
//    legal read  -> READ;  prdata <= mux value sampled at that edge; pslverr <= 0
//    legal write -> WRITE; pslverr <= 0
//    write to 0,1,6, any access to 5/7, or write of illegal data_size -> ERROR; pslverr <= 1, prdata <= 0
//   READ/WRITE/ERROR: last one cycle (access phase), then IDLE; pslverr and prdata return to 0 at the edge ending the access cycle.
//  Writes: register updated at the edge ending the WRITE access cycle. data_size accepts only 5, 7, 8 (pwdata[3:0]);
//   any other value -> ERROR, register unchanged. A write to addr 4 with nonzero pwdata[7:4] is still legal (bits ignored).
//  data_read: registered, high for exactly the one cycle following the READ access of addr 6; never for other addresses.
//   The RX buffer clears data_ready on that edge; status read back-to-back returns 0 unless a new packet loaded same cycle.
//  Read of addr 6 with data_ready=0: legal, returns current rx_data (reset pattern 8'hFF masked by size), still pulses data_read.
//  Protocol violation (penable=1 in IDLE without preceding setup): ignored, no state change, no strobe.
//  psel dropped during access cycle: FSM still returns to IDLE next edge; a pending write is discarded.
//  data_size change while a packet is in the buffer: mask uses data_size value at the read's setup edge.
//  Reset mid-transfer: all outputs to reset values immediately; a write in progress is lost.
// TESTING
//  1 Reset -> bit_period=10, data_size=8, prdata=0, pslverr=0, data_read=0; read addr 2 -> 8'h0A, addr 3 -> 8'h00.
//  2 Write addr2=8'h34, addr3=8'h12 -> bit_period=14'h1234; read back 8'h34/8'h12, pslverr=0.
//  3 data_ready=1, rx_data=8'hA5, size 8: read addr6 -> prdata 8'hA5, data_read high exactly 1 cycle; size 5 -> 8'h14.
//  4 Write addr4=8'h06 -> pslverr=1, data_size stays 8; write addr0 or read addr5 -> pslverr=1, prdata=0.
//  5 overrun_error=1, framing_error=1 -> read addr1 = 8'h03; read addr0 with data_ready=1 = 8'h01, no data_read pulse.
//  6 Assert n_rst mid-write of addr4=8'h05 -> data_size returns 8, pslverr/data_read 0 asynchronously.

Source files
------------

// File: rtl/apb_uart_slave.sv
// apb_uart_slave: APB register interface for the UART receiver.
//   Exposes RX status, error flags and the buffered data byte, holds the
//   programmable bit period / data size, and strobes data_read when the
//   host consumes a packet through the data register.
// Ports:
//   clk, n_rst                  clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata   APB request
//   prdata, pslverr             APB response (registered)
//   rx_data, data_ready, overrun_error, framing_error   RX buffer side
//   data_read                   one-cycle consume strobe
//   bit_period, data_size       receiver configuration
module apb_uart_slave #(
    parameter int unsigned BP_W   = 14,
    parameter int unsigned BP_RST = 10,
    parameter int unsigned DS_RST = 8
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [2:0]      paddr,
    input  logic [7:0]      pwdata,
    output logic [7:0]      prdata,
    output logic            pslverr,
    input  logic [7:0]      rx_data,
    input  logic            data_ready,
    input  logic            overrun_error,
    input  logic            framing_error,
    output logic            data_read,
    output logic [BP_W-1:0] bit_period,
    output logic [3:0]      data_size
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, ERROR} state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        setup_c;
    logic        size_ok_c;
    logic        rd_legal_c;
    logic        wr_legal_c;
    logic [7:0]  rx_masked_c;
    logic [7:0]  rd_mux_c;

    // Request decode, evaluated during the setup cycle
    always_comb begin
        setup_c    = psel & ~penable;
        size_ok_c  = (pwdata[3:0] == 4'd5) || (pwdata[3:0] == 4'd7) ||
                     (pwdata[3:0] == 4'd8);
        rd_legal_c = (paddr != 3'd5) && (paddr != 3'd7);
        wr_legal_c = (paddr == 3'd2) || (paddr == 3'd3) ||
                     ((paddr == 3'd4) && size_ok_c);
    end

    // Right-justify the received byte by the configured data size
    always_comb begin
        case (data_size)
            4'd7:    rx_masked_c = {1'b0, rx_data[7:1]};
            4'd5:    rx_masked_c = {3'b0, rx_data[7:3]};
            default: rx_masked_c = rx_data;
        endcase
    end

    // Read data mux
    always_comb begin
        rd_mux_c = 8'h00;
        case (paddr)
            3'd0:    rd_mux_c = {7'b0, data_ready};
            3'd1:    rd_mux_c = {6'b0, overrun_error, framing_error};
            3'd2:    rd_mux_c = bit_period[7:0];
            3'd3:    rd_mux_c = 8'(bit_period[BP_W-1:8]);
            3'd4:    rd_mux_c = {4'b0, data_size};
            3'd6:    rd_mux_c = rx_masked_c;
            default: rd_mux_c = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: every non-IDLE state is a single access cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (setup_c) begin
                    if (!pwrite && rd_legal_c)     state_next = READ;
                    else if (pwrite && wr_legal_c) state_next = WRITE;
                    else                           state_next = ERROR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and configuration registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prdata     <= 8'h00;
            pslverr    <= 1'b0;
            data_read  <= 1'b0;
            bit_period <= BP_W'(BP_RST);
            data_size  <= 4'(DS_RST);
            addr_q     <= 3'd0;
            wdata_q    <= 8'h00;
        end else begin
            data_read <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup_c) begin
                        addr_q  <= paddr;
                        wdata_q <= pwdata;
                        pslverr <= (state_next == ERROR);
                        prdata  <= (state_next == READ) ? rd_mux_c : 8'h00;
                    end
                end
                READ: begin
                    prdata    <= 8'h00;
                    pslverr   <= 1'b0;
                    data_read <= (addr_q == 3'd6);
                end
                WRITE: begin
                    prdata  <= 8'h00;
                    pslverr <= 1'b0;
                    // Write commits only if the master is still selecting us
                    if (psel && penable) begin
                        case (addr_q)
                            3'd2:    bit_period[7:0]      <= wdata_q;
                            3'd3:    bit_period[BP_W-1:8] <= wdata_q[BP_W-9:0];
                            3'd4:    data_size            <= wdata_q[3:0];
                            default: ;
                        endcase
                    end
                end
                default: begin
                    prdata  <= 8'h00;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_slave.sv
// tb_apb_uart_slave: directed and randomized bench for apb_uart_slave.
module tb_apb_uart_slave;

    logic        clk;
    logic        n_rst;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pslverr;
    logic [7:0]  rx_data;
    logic        data_ready, overrun_error, framing_error;
    logic        data_read;
    logic [13:0] bit_period;
    logic [3:0]  data_size;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_bp = 10;
    int m_ds = 8;

    apb_uart_slave #(.BP_W(14), .BP_RST(10), .DS_RST(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pslverr(pslverr),
        .rx_data(rx_data), .data_ready(data_ready),
        .overrun_error(overrun_error), .framing_error(framing_error),
        .data_read(data_read), .bit_period(bit_period), .data_size(data_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full APB transfer plus one trailing idle cycle
    task automatic xfer(input logic w, input logic [2:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic err,
                        output logic dr1, output logic dr2,
                        output logic [7:0] rd_after, output logic err_after);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        dr1 = data_read; rd_after = prdata; err_after = pslverr;
        @(posedge clk); #1;
        dr2 = data_read;
    endtask

    // Register-map reference: plain arithmetic on the model values
    function automatic logic [7:0] model_read(input int a);
        case (a)
            0:       return 8'(data_ready);
            1:       return 8'(overrun_error * 2 + framing_error);
            2:       return 8'(m_bp % 256);
            3:       return 8'(m_bp / 256);
            4:       return 8'(m_ds);
            6:       return 8'(rx_data >> (8 - m_ds));
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic model_err(input logic w, input int a, input logic [7:0] d);
        int sz;
        sz = d % 16;
        if (!w) return (a == 5) || (a == 7);
        if (a == 2 || a == 3) return 1'b0;
        if (a == 4 && (sz == 5 || sz == 7 || sz == 8)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_write(input int a, input logic [7:0] d);
        if (a == 2) m_bp = (m_bp / 256) * 256 + d;
        else if (a == 3) m_bp = (d % 64) * 256 + (m_bp % 256);
        else if (a == 4) m_ds = d % 16;
    endtask

    logic [7:0] rd, rd_after;
    logic       err, dr1, dr2, err_after;

    initial begin
        n_rst = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 3'd0; pwdata = 8'h00;
        rx_data = 8'hFF; data_ready = 1'b0; overrun_error = 1'b0; framing_error = 1'b0;

        // 1: reset values
        #12;
        chk("rst_bit_period", 32'(bit_period), 32'd10);
        chk("rst_data_size", 32'(data_size), 32'd8);
        chk("rst_prdata", 32'(prdata), 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_data_read", 32'(data_read), 32'h0);
        @(negedge clk); n_rst = 1'b1;
        xfer(1'b0, 3'd2, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("rst_rd_addr2", 32'(rd), 32'h0A);
        chk("rst_rd_addr2_err", 32'(err), 32'h0);
        xfer(1'b0, 3'd3, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("rst_rd_addr3", 32'(rd), 32'h00);

        // 2: bit period write / readback
        xfer(1'b1, 3'd2, 8'h34, rd, err, dr1, dr2, rd_after, err_after);
        chk("wr_addr2_err", 32'(err), 32'h0);
        xfer(1'b1, 3'd3, 8'h12, rd, err, dr1, dr2, rd_after, err_after);
        chk("wr_addr3_err", 32'(err), 32'h0);
        chk("bit_period_1234", 32'(bit_period), 32'h1234);
        xfer(1'b0, 3'd2, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("rb_addr2", 32'(rd), 32'h34);
        xfer(1'b0, 3'd3, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("rb_addr3", 32'(rd), 32'h12);
        chk("rb_addr3_err", 32'(err), 32'h0);
        m_bp = 32'h1234;

        // 3: data register, size 8 then 5
        rx_data = 8'hA5; data_ready = 1'b1;
        xfer(1'b0, 3'd6, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("rx_size8", 32'(rd), 32'hA5);
        chk("rx_size8_strobe", 32'(dr1), 32'h1);
        chk("rx_size8_strobe_end", 32'(dr2), 32'h0);
        chk("rx_prdata_clear", 32'(rd_after), 32'h0);
        xfer(1'b1, 3'd4, 8'h05, rd, err, dr1, dr2, rd_after, err_after);
        chk("size5_err", 32'(err), 32'h0);
        chk("size5_reg", 32'(data_size), 32'd5);
        xfer(1'b0, 3'd6, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("rx_size5", 32'(rd), 32'h14);
        chk("rx_size5_strobe", 32'(dr1), 32'h1);

        // 4: error cases
        xfer(1'b1, 3'd4, 8'h08, rd, err, dr1, dr2, rd_after, err_after);
        xfer(1'b1, 3'd4, 8'h06, rd, err, dr1, dr2, rd_after, err_after);
        chk("bad_size_err", 32'(err), 32'h1);
        chk("bad_size_err_clear", 32'(err_after), 32'h0);
        chk("bad_size_keep", 32'(data_size), 32'd8);
        xfer(1'b1, 3'd0, 8'h55, rd, err, dr1, dr2, rd_after, err_after);
        chk("wr_ro_err", 32'(err), 32'h1);
        chk("wr_ro_prdata", 32'(rd), 32'h0);
        xfer(1'b0, 3'd5, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("rd_unmapped_err", 32'(err), 32'h1);
        chk("rd_unmapped_prdata", 32'(rd), 32'h0);
        chk("rd_unmapped_nostrobe", 32'(dr1), 32'h0);

        // 5: status / error flags
        overrun_error = 1'b1; framing_error = 1'b1;
        xfer(1'b0, 3'd1, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("errors_03", 32'(rd), 32'h03);
        xfer(1'b0, 3'd0, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("status_01", 32'(rd), 32'h01);
        chk("status_nostrobe", 32'(dr1), 32'h0);

        // Upper nibble of data_size write is ignored
        xfer(1'b1, 3'd4, 8'hF7, rd, err, dr1, dr2, rd_after, err_after);
        chk("size_hi_nibble_err", 32'(err), 32'h0);
        chk("size_hi_nibble_reg", 32'(data_size), 32'd7);
        m_ds = 7;

        // Protocol violation: penable without setup is ignored
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'h99;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("viol_pslverr", 32'(pslverr), 32'h0);
        chk("viol_bit_period", 32'(bit_period), 32'h1234);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;

        // psel dropped during access: write discarded
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd2; pwdata = 8'h55;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b1;
        @(posedge clk); #1;
        penable = 1'b0; pwrite = 1'b0;
        chk("drop_psel_keep", 32'(bit_period), 32'h1234);
        xfer(1'b0, 3'd2, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("drop_psel_readback", 32'(rd), 32'h34);

        // Randomized transfers against the model
        for (int i = 0; i < 60; i++) begin
            logic       w;
            int         a;
            logic [7:0] d;
            logic       e_err;
            w = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 7);
            d = 8'($urandom);
            if (a == 4 && $urandom_range(0, 1) == 1)
                d = {d[7:4], ($urandom_range(0, 2) == 0) ? 4'd5 :
                             ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8};
            rx_data = 8'($urandom);
            data_ready = 1'($urandom_range(0, 1));
            overrun_error = 1'($urandom_range(0, 1));
            framing_error = 1'($urandom_range(0, 1));
            e_err = model_err(w, a, d);
            xfer(w, 3'(a), d, rd, err, dr1, dr2, rd_after, err_after);
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(e_err));
            if (!w) chk($sformatf("rnd%0d_rd", i), 32'(rd), 32'(model_read(a)));
            chk($sformatf("rnd%0d_strobe", i), 32'(dr1), 32'(!w && a == 6));
            chk($sformatf("rnd%0d_strobe_end", i), 32'(dr2), 32'h0);
            chk($sformatf("rnd%0d_idle_resp", i), 32'({rd_after, err_after}), 32'h0);
            if (w && !e_err) model_write(a, d);
            chk($sformatf("rnd%0d_bp", i), 32'(bit_period), 32'(m_bp));
            chk($sformatf("rnd%0d_ds", i), 32'(data_size), 32'(m_ds));
        end

        // 6: reset mid-write of data_size
        xfer(1'b1, 3'd4, 8'h07, rd, err, dr1, dr2, rd_after, err_after);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd4; pwdata = 8'h05;
        @(posedge clk); #1;
        penable = 1'b1;
        #2; n_rst = 1'b0; #1;
        chk("rst_mid_size", 32'(data_size), 32'd8);
        chk("rst_mid_pslverr", 32'(pslverr), 32'h0);
        chk("rst_mid_data_read", 32'(data_read), 32'h0);
        chk("rst_mid_bit_period", 32'(bit_period), 32'd10);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk); n_rst = 1'b1;

        // Reset during an error access clears pslverr immediately
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd4; pwdata = 8'h06;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("err_before_rst", 32'(pslverr), 32'h1);
        #2; n_rst = 1'b0; #1;
        chk("err_async_clear", 32'(pslverr), 32'h0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        m_bp = 10; m_ds = 8;
        xfer(1'b0, 3'd4, 8'h00, rd, err, dr1, dr2, rd_after, err_after);
        chk("post_rst_size_rd", 32'(rd), 32'h08);
        chk("post_rst_size_err", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
